// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with per-register in-flight write scoreboard.
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_busy,
  output logic              B_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              iss_ready,
  input  logic              W,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              wb_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic wr_eff, iss_acc, inc, dec;
  logic byp_a, byp_b, byp_iss;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b1}});
  endfunction

  assign wr_eff = W && !is_zero(DA);

`ifdef REGFILE_BYPASS_EN
  assign byp_a   = wr_eff && (DA == SA);
  assign byp_b   = wr_eff && (DA == SB);
  assign byp_iss = wr_eff && (DA == iss_dst);
`else
  assign byp_a   = 1'b0;
  assign byp_b   = 1'b0;
  assign byp_iss = 1'b0;
`endif

  always_comb begin
    A      = is_zero(SA) ? '0 : regs_q[SA];
    B      = is_zero(SB) ? '0 : regs_q[SB];
    A_busy = busy_q[SA] && !is_zero(SA);
    B_busy = busy_q[SB] && !is_zero(SB);
    if (byp_a) begin
      A      = D;
      A_busy = 1'b0;
    end
    if (byp_b) begin
      B      = D;
      B_busy = 1'b0;
    end
  end

  assign iss_ready = is_zero(iss_dst) || !busy_q[iss_dst] || byp_iss;
  assign iss_acc   = iss_valid && iss_ready && !is_zero(iss_dst);

  // Issue on a register whose writeback lands this same cycle keeps the bit set,
  // so neither the increment nor the clear counts in that case.
  assign inc = iss_acc && !busy_q[iss_dst];
  assign dec = wr_eff && busy_q[DA] && !(iss_acc && (iss_dst == DA));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (wr_eff) begin
      busy_d[DA] = 1'b0;
      if (!busy_q[DA]) err_d = 1'b1;
    end
    if (iss_acc) busy_d[iss_dst] = 1'b1;
    if (inc && !dec)      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wr_eff) regs_q[DA] <= D;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign wb_err   = err_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised 2-read/1-write register file with an integrated per-register scoreboard for the pipelined datapath. Tracks registers with an in-flight write (issued, not yet written back) and reports busy status on each read port. Provides an issue handshake that blocks write-after-write hazards. The top address is optionally hardwired to zero (XZR-style).

Parameters:
DATA_W, 64, width of each register and of the data buses
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = address 2**ADDR_W-1 reads 0, ignores writes, is never busy

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (sampled on the rising edge of clock)
SA  in  ADDR_W  read port A address
SB  in  ADDR_W  read port B address
A  out  DATA_W  read port A data (combinational)
B  out  DATA_W  read port B data (combinational)
A_busy  out  1  register SA has a pending write
B_busy  out  1  register SB has a pending write
iss_valid  in  1  issue request: claims destination iss_dst
iss_dst  in  ADDR_W  destination register being issued
iss_ready  out  1  issue accepted this cycle when iss_valid & iss_ready
W  in  1  writeback enable
DA  in  ADDR_W  writeback address
D  in  DATA_W  writeback data
busy_cnt  out  ADDR_W+1  number of busy registers
wb_err  out  1  sticky: writeback hit a non-busy, non-zero register

Behaviour:
- Reset (reset==0 at a clock edge): all registers cleared to 0, all busy bits cleared, busy_cnt=0, wb_err=0. Overrides same-cycle issue and writeback.
- Reads: A=reg[SA], B=reg[SB], combinational, zero latency. With ZERO_REG=1, the zero address reads 0 and A_busy/B_busy=0.
- Write: on a clock edge with W=1, reg[DA]<=D; visible on A/B the next cycle. Writes to the zero address are ignored (ZERO_REG=1).
- iss_ready = !busy[iss_dst]. It is 1 for the zero address and does not depend on iss_valid.
- Issue accepted (iss_valid & iss_ready): busy[iss_dst]<=1 at the edge. Issue to the zero address is a no-op.
- Writeback with W=1: busy[DA]<=0 at the edge.
- Same-cycle issue and writeback to the same address X: issue wins, busy[X] stays 1. X can only be accepted when not busy, so that writeback also sets wb_err.
- Writeback to a register that is not busy: data is still written; wb_err<=1, sticky until reset.
- busy_cnt: +1 on an effective issue, -1 on an effective clear, net 0 when both occur on different registers. Never underflows, because clearing a non-busy bit does not decrement. Max value 2**ADDR_W-ZERO_REG.
- No busy bit changes without an accepted issue or a writeback.
- Reset deasserting mid-sequence: in-flight ops before reset are forgotten, and a writeback after reset to the old destination sets wb_err.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read bypass. If W=1, DA==SA and DA is not the zero address, then A=D and A_busy=0 in the same cycle; likewise for B/SB. iss_ready also treats a register being written back this cycle as free.
- Undefined: no bypass. A/B show the stored value, busy flags and iss_ready reflect registered state only; the new value is visible one cycle after the write.

Test Plan:
- Reset: write reg3=0xDEAD, issue reg5, then hold reset=0 one edge -> A(SA=3)=0, A_busy(SA=5)=0, busy_cnt=0, wb_err=0.
- Issue and writeback: issue dst=7, then read SA=7 -> A_busy=1, busy_cnt=1. Issue dst=7 again -> iss_ready=0, busy_cnt stays 1. Write D=0x1234 to DA=7 -> next cycle A=0x1234, A_busy=0, busy_cnt=0.
- Zero register (ZERO_REG=1): issue dst=31 and write D=0xFFFF to DA=31 -> A(SA=31)=0, busy_cnt=0, iss_ready=1, wb_err=0.
- Collision: reg9 busy, reg4 free; issue dst=4 with writeback DA=9 in the same cycle -> busy[4]=1, busy[9]=0, busy_cnt unchanged.
- Spurious writeback: write DA=2 with reg2 not busy -> reg2 updated, wb_err=1 and stays 1 until reset.
- Bypass (macro defined): reg6 busy and holding 0; SA=6, W=1, DA=6, D=0xABCD in the same cycle -> A=0xABCD, A_busy=0 that cycle. With the macro undefined -> A=0, A_busy=1 that cycle, and A=0xABCD, A_busy=0 the next cycle.
